// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_WAIT,
    ST_WR,
    RMW_RD,
    RMW_MERGE,
    RMW_WR,
    RESP
  } lsu_state_t;

  // Replace the byte or halfword lane selected by offset; the memory has no byte enables.
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                 input logic [15:0]     lane_data,
                                                 input logic [1:0]      offset,
                                                 input logic [2:0]      funct3);
    logic [XLEN-1:0] merged;
    merged = word;
    if (funct3 == F3_H) merged[{offset[1], 4'b0000} +: 16] = lane_data;
    else                merged[{offset, 3'b000} +: 8]      = lane_data[7:0];
    return merged;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      offset,
                                                  input logic [2:0]      funct3);
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] result;
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_BU:   result = {24'd0, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_HU:   result = {16'd0, lane_h};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed lane and extends it to a full word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  assign result = load_extend(word, offset, funct3);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, 1-cycle-read data memory.
// Sub-word stores are done as read-modify-write; faults respond without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          addr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic                 rsp_valid_o,
  output logic [DATAWIDTH-1:0] rdata_o,
  output logic                 misaligned_o,
  output logic                 illegal_o,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  lsu_state_t             state_q, state_d;
  logic [2:0]             funct3_q;
  logic [ADDRWIDTH+1:0]   addr_q;
  logic [DATAWIDTH-1:0]   wdata_q, merge_q, rdata_q, load_result;
  logic                   misaligned_q, illegal_q;
  logic                   illegal_req, misaligned_req, accept;
  logic                   cs, we;
  logic [DATAWIDTH-1:0]   wdata_mux;
  logic                   unused_addr_bits;

  // Word addresses wrap: bits above the memory size are intentionally dropped.
  assign unused_addr_bits = ^addr_i[31:ADDRWIDTH+2];

  assign illegal_req = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111)
                     || (req_write_i && funct3_i[2]);
  assign misaligned_req = !illegal_req
                        && (((funct3_i[1:0] == 2'b01) && addr_i[0])
                         || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
  assign accept = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cs          = 1'b0;
    we          = 1'b0;
    wdata_mux   = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (illegal_req || misaligned_req) state_d = RESP;
          else if (!req_write_i)              state_d = LD_RD;
          else if (funct3_i[1:0] == 2'b10)    state_d = ST_WR;
          else                                state_d = RMW_RD;
        end
      end
      LD_RD:     begin cs = 1'b1; state_d = LD_WAIT; end
      LD_WAIT:   state_d = RESP;
      ST_WR:     begin cs = 1'b1; we = 1'b1; wdata_mux = wdata_q; state_d = RESP; end
      RMW_RD:    begin cs = 1'b1; state_d = RMW_MERGE; end
      RMW_MERGE: state_d = RMW_WR;
      RMW_WR:    begin cs = 1'b1; we = 1'b1; wdata_mux = merge_q; state_d = RESP; end
      RESP:      begin rsp_valid_o = 1'b1; state_d = IDLE; end
      default:   state_d = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .word   (mem_rdata_i),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (load_result)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: only the architecturally visible response registers are reset; request and
    // merge registers are always written before they are read.
    if (rst_i) begin
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= funct3_i;
        addr_q   <= addr_i[ADDRWIDTH+1:0];
        wdata_q  <= wdata_i;
        if (illegal_req || misaligned_req) begin
          rdata_q      <= '0;
          misaligned_q <= misaligned_req;
          illegal_q    <= illegal_req;
        end
      end
      if (state_q == RMW_MERGE)
        merge_q <= lane_merge(mem_rdata_i, wdata_q[15:0], addr_q[1:0], funct3_q);
      if (state_q == LD_WAIT || state_q == ST_WR || state_q == RMW_WR) begin
        rdata_q      <= (state_q == LD_WAIT) ? load_result : '0;
        misaligned_q <= 1'b0;
        illegal_q    <= 1'b0;
      end
    end
  end

  assign rdata_o      = rdata_q;
  assign misaligned_o = misaligned_q;
  assign illegal_o    = illegal_q;

  // Reset must block any memory strobe, including one in the middle of a read-modify-write.
  assign mem_cs_o    = cs && !rst_i;
  assign mem_we_o    = we && !rst_i;
  assign mem_addr_o  = mem_cs_o ? addr_q[ADDRWIDTH+1:2] : '0;
  assign mem_wdata_o = mem_cs_o ? wdata_mux : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, byte-arithmetic reference model,
// directed scenarios and randomized traffic.
module tb_load_store_unit;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, rdata_o;
  logic        rsp_valid_o, misaligned_o, illegal_o;
  logic        mem_cs_o, mem_we_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  load_store_unit #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
    .clk_i, .rst_i, .req_valid_i, .req_ready_o, .req_write_i, .funct3_i, .addr_i, .wdata_i,
    .rsp_valid_o, .rdata_o, .misaligned_o, .illegal_o,
    .mem_cs_o, .mem_we_o, .mem_addr_o, .mem_wdata_o, .mem_rdata_i
  );

  always #5 clk_i = ~clk_i;

  // Data memory: registered read, write on cs & we.
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge clk_i) begin
    if (mem_cs_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= mem[mem_addr_o];
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          we_count = 0, rsp_count = 0;
  int          rsp_cyc_q[$], acc_cyc_q[$];
  logic [31:0] rsp_data_q[$];
  always @(negedge clk_i) begin
    if (mem_we_o) we_count++;
    if (rsp_valid_o) begin
      rsp_count++;
      rsp_cyc_q.push_back(cyc);
      rsp_data_q.push_back(rdata_o);
    end
    if (req_valid_i && req_ready_o) acc_cyc_q.push_back(cyc);
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: memory as an array of words, lanes handled with shifts and masks.
  logic [31:0] ref_mem [32];
  initial for (int i = 0; i < 32; i++) ref_mem[i] = '0;

  task automatic model_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] e_rd,
                           output logic e_mis, output logic e_ill, output int e_lat);
    int     nbytes, idx;
    longint mask, shift, word, v;
    nbytes = 1 << f3[1:0];
    e_ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    e_mis  = !e_ill && ((a % nbytes) != 0);
    e_rd   = '0;
    e_lat  = 1;
    if (e_ill || e_mis) return;
    idx   = int'((a / 4) % 32);
    shift = longint'(a % 4) * 8;
    mask  = (longint'(1) << (8 * nbytes)) - 1;
    word  = longint'(ref_mem[idx]);
    if (!wr) begin
      v = (word >> shift) & mask;
      if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      e_rd  = v[31:0];
      e_lat = 3;
    end else begin
      word        = (word & ~(mask << shift)) | ((longint'(wd) & mask) << shift);
      ref_mem[idx] = word[31:0];
      e_lat       = (nbytes == 4) ? 2 : 4;
    end
  endtask

  // Issues one request from an idle DUT and observes it until its response (bounded).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                        output logic ill, output int lat, output logic cs_seen,
                        output int rd_cyc, output int wr_cyc, output logic [31:0] wr_data);
    rd = 32'hDEAD_BEEF; mis = 1'bx; ill = 1'bx; lat = 0;
    cs_seen = 1'b0; rd_cyc = 0; wr_cyc = 0; wr_data = '0;
    check("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (mem_cs_o) begin
        cs_seen = 1'b1;
        if (mem_we_o) begin wr_cyc = k; wr_data = mem_wdata_o; end
        else rd_cyc = k;
      end
      if (rsp_valid_o) begin
        lat = k; rd = rdata_o; mis = misaligned_o; ill = illegal_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
  endtask

  logic [31:0] g_rd, g_wr_data;
  logic        g_cs;
  int          g_rd_cyc, g_wr_cyc;

  task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] e_rd, rd;
    logic        e_mis, e_ill, mis, ill;
    int          e_lat, lat;
    model_req(wr, f3, a, wd, e_rd, e_mis, e_ill, e_lat);
    do_req(wr, f3, a, wd, rd, mis, ill, lat, g_cs, g_rd_cyc, g_wr_cyc, g_wr_data);
    g_rd = rd;
    check({tag, "_rdata"}, rd, e_rd);
    check({tag, "_misaligned"}, 32'(mis), 32'(e_mis));
    check({tag, "_illegal"}, 32'(ill), 32'(e_ill));
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    if (e_mis || e_ill) check({tag, "_no_cs"}, 32'(g_cs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_we, base_rsp;
    logic [31:0] ea, eb, dummy;
    logic        m0, i0;
    int          l0;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ready", 32'(req_ready_o), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_flags", {30'd0, misaligned_o, illegal_o}, 32'd0);
    check("reset_cs", 32'(mem_cs_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Sign/zero extension on a word with negative lanes.
    run_req("sw_0c", 1'b1, F_W, 32'h0C, 32'h80FF7F01);
    run_req("lb_0e", 1'b0, F_B, 32'h0E, '0);
    check("lb_0e_const", g_rd, 32'hFFFFFFFF);
    run_req("lbu_0e", 1'b0, F_BU, 32'h0E, '0);
    check("lbu_0e_const", g_rd, 32'h000000FF);
    run_req("lh_0e", 1'b0, F_H, 32'h0E, '0);
    check("lh_0e_const", g_rd, 32'hFFFF80FF);
    run_req("lhu_0e", 1'b0, F_HU, 32'h0E, '0);
    check("lhu_0e_const", g_rd, 32'h000080FF);
    run_req("lb_0c", 1'b0, F_B, 32'h0C, '0);
    check("lb_0c_const", g_rd, 32'h00000001);

    // Byte read-modify-write strobe timing.
    run_req("sw_10", 1'b1, F_W, 32'h10, 32'h11223344);
    run_req("sb_11", 1'b1, F_B, 32'h11, 32'h000000AA);
    check("sb_11_rd_cycle", 32'(g_rd_cyc), 32'd1);
    check("sb_11_wr_cycle", 32'(g_wr_cyc), 32'd3);
    check("sb_11_wr_data", g_wr_data, 32'h1122AA44);
    run_req("lw_10_after_sb", 1'b0, F_W, 32'h10, '0);
    check("lw_10_after_sb_const", g_rd, 32'h1122AA44);

    // Upper halfword store.
    run_req("sw_10b", 1'b1, F_W, 32'h10, 32'h11223344);
    run_req("sh_12", 1'b1, F_H, 32'h12, 32'h0000BEEF);
    run_req("lw_10_after_sh", 1'b0, F_W, 32'h10, '0);
    check("lw_10_after_sh_const", g_rd, 32'hBEEF3344);

    // Faults.
    run_req("lw_06_mis", 1'b0, F_W, 32'h06, '0);
    run_req("sh_03_mis", 1'b1, F_H, 32'h03, 32'h1234);
    run_req("f3_011_ill", 1'b0, 3'b011, 32'h04, '0);
    run_req("sbu_ill", 1'b1, F_BU, 32'h01, 32'h55);

    // Reset during the merge cycle of a byte RMW.
    run_req("sw_10c", 1'b1, F_W, 32'h10, 32'h11223344);
    base_we = we_count; base_rsp = rsp_count;
    req_valid_i = 1'b1; req_write_i = 1'b1; funct3_i = F_B; addr_i = 32'h11; wdata_i = 32'hAA;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    check("rst_mid_rsp", 32'(rsp_valid_o), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("rst_mid_no_we", 32'(we_count), 32'(base_we));
    check("rst_mid_no_rsp", 32'(rsp_count), 32'(base_rsp));
    run_req("lw_10_after_rst", 1'b0, F_W, 32'h10, '0);
    check("lw_10_after_rst_const", g_rd, 32'h11223344);

    // Two back-to-back loads with req_valid_i held high.
    model_req(1'b0, F_W, 32'h10, '0, ea, m0, i0, l0);
    model_req(1'b0, F_B, 32'h0C, '0, eb, m0, i0, l0);
    acc_cyc_q.delete(); rsp_cyc_q.delete(); rsp_data_q.delete();
    req_valid_i = 1'b1; req_write_i = 1'b0; funct3_i = F_W; addr_i = 32'h10;
    @(posedge clk_i); #1;
    funct3_i = F_B; addr_i = 32'h0C;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i); #1;
      if (acc_cyc_q.size() >= 2) break;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    check("queued_accepts", 32'(acc_cyc_q.size()), 32'd2);
    check("queued_accept_gap", 32'((acc_cyc_q.size() >= 2) ? acc_cyc_q[1] - acc_cyc_q[0] : -1), 32'd4);
    check("queued_rsps", 32'(rsp_cyc_q.size()), 32'd2);
    check("queued_rsp_gap", 32'((rsp_cyc_q.size() >= 2) ? rsp_cyc_q[1] - rsp_cyc_q[0] : -1), 32'd4);
    check("queued_rdata_a", (rsp_data_q.size() >= 1) ? rsp_data_q[0] : 32'hDEAD_BEEF, ea);
    check("queued_rdata_b", (rsp_data_q.size() >= 2) ? rsp_data_q[1] : 32'hDEAD_BEEF, eb);

    // Randomized traffic: fill memory, then mixed ops including faults and address wrap.
    for (int i = 0; i < 32; i++) run_req("rnd_fill", 1'b1, F_W, 32'(i * 4), $urandom());
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'(a[1:0] & {1'b1, $urandom_range(0, 1) == 1});
      run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              a, $urandom());
    end
    for (int i = 0; i < 32; i++) begin
      run_req($sformatf("rnd_sweep%0d", i), 1'b0, F_W, 32'(i * 4), '0);
    end
    dummy = g_rd;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
